// File: rtl/fp_align_ctrl.sv
// fp_align_ctrl: binary32 operand-alignment controller driving a 24-bit right-shift mantissa register.
// Optional FP_ALIGN_STICKY_EN adds a shadow mantissa that accumulates the shifted-out sticky bit.
module fp_align_ctrl #(
  parameter int MAX_SHIFT = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [22:0] sr_data,
  output logic        sr_load,
  output logic        sr_shift,
  output logic        sr_clear,
  output logic [7:0]  exp_out,
  output logic [22:0] big_frac,
  output logic        sign_big,
  output logic        eff_sub,
  output logic        swap,
  output logic        sticky
);
  typedef enum logic [2:0] {S_IDLE, S_CMP, S_LOAD, S_SHIFT, S_DONE} state_t;
  state_t      r_state;
  logic [31:0] r_a, r_b;
  logic [7:0]  r_exp, r_cnt;
  logic [22:0] r_big_frac, r_sr_data;
  logic        r_sign_big, r_eff_sub, r_swap, r_flush;
  // Magnitude order of binary32 equals unsigned order of bits [30:0]; ties keep A as big.
  logic        w_a_big;
  logic [31:0] w_big, w_small;
  logic [7:0]  w_diff;
  logic        w_flush;
  assign w_a_big = r_a[30:0] >= r_b[30:0];
  assign w_big   = w_a_big ? r_a : r_b;
  assign w_small = w_a_big ? r_b : r_a;
  assign w_diff  = w_big[30:23] - w_small[30:23];
  assign w_flush = (w_small[30:23] == 8'd0) || (w_diff >= 8'(MAX_SHIFT));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_exp      <= '0;
      r_cnt      <= '0;
      r_big_frac <= '0;
      r_sr_data  <= '0;
      r_sign_big <= 1'b0;
      r_eff_sub  <= 1'b0;
      r_swap     <= 1'b0;
      r_flush    <= 1'b0;
    end else
      case (r_state)
        S_IDLE: if (start) begin
          r_a     <= a;
          r_b     <= b;
          r_state <= S_CMP;
        end
        S_CMP: begin
          r_exp      <= w_big[30:23];
          r_big_frac <= w_big[22:0];
          r_sign_big <= w_big[31];
          r_eff_sub  <= r_a[31] ^ r_b[31];
          r_swap     <= !w_a_big;
          r_sr_data  <= w_small[22:0];
          r_cnt      <= w_diff;
          r_flush    <= w_flush;
          r_state    <= S_LOAD;
        end
        S_LOAD:  r_state <= (!r_flush && r_cnt != 8'd0) ? S_SHIFT : S_DONE;
        S_SHIFT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
  assign busy     = r_state != S_IDLE;
  assign done     = r_state == S_DONE;
  assign sr_load  = (r_state == S_LOAD) && !r_flush;
  assign sr_clear = (r_state == S_LOAD) && r_flush;
  assign sr_shift = r_state == S_SHIFT;
  assign sr_data  = r_sr_data;
  assign exp_out  = r_exp;
  assign big_frac = r_big_frac;
  assign sign_big = r_sign_big;
  assign eff_sub  = r_eff_sub;
  assign swap     = r_swap;
`ifdef FP_ALIGN_STICKY_EN
  logic [23:0] r_shadow;
  logic        r_sticky, r_small_nz;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_shadow   <= '0;
      r_sticky   <= 1'b0;
      r_small_nz <= 1'b0;
    end else if (r_state == S_CMP) begin
      r_sticky   <= 1'b0;
      r_small_nz <= w_small[30:23] != 8'd0;
    end else if (r_state == S_LOAD) begin
      r_shadow <= {1'b1, r_sr_data};
      if (r_flush) r_sticky <= r_small_nz;
    end else if (r_state == S_SHIFT) begin
      r_sticky <= r_sticky | r_shadow[0];
      r_shadow <= r_shadow >> 1;
    end
  assign sticky = r_sticky;
`else
  assign sticky = 1'b0;
`endif
endmodule

// File: tb/tb_fp_align_ctrl.sv
// tb_fp_align_ctrl: scoreboard bench for fp_align_ctrl with a behavioural downstream shift register.
module tb_fp_align_ctrl;
  logic        clk = 0, rst_n = 0, start = 0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, sr_load, sr_shift, sr_clear, sign_big, eff_sub, swap, sticky;
  logic [22:0] sr_data, big_frac;
  logic [7:0]  exp_out;
  int n_vec = 0, n_bad = 0;

  typedef struct packed {
    logic [7:0]  lat;
    logic [7:0]  nld;
    logic [7:0]  nsh;
    logic [7:0]  ncl;
    logic [23:0] sreg;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        sgn, sub, swp, stk, bad;
  } res_t;
  res_t exp_q[$];

  fp_align_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .busy(busy), .done(done),
    .sr_data(sr_data), .sr_load(sr_load), .sr_shift(sr_shift), .sr_clear(sr_clear),
    .exp_out(exp_out), .big_frac(big_frac), .sign_big(sign_big), .eff_sub(eff_sub),
    .swap(swap), .sticky(sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1);
  end

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t r;
    logic [31:0] bg, sm;
    logic [23:0] m;
    logic [7:0] d;
    logic fl, ab;
    ab = x[30:0] >= y[30:0];
    bg = ab ? x : y;
    sm = ab ? y : x;
    d  = bg[30:23] - sm[30:23];
    fl = (sm[30:23] == 8'd0) || (d >= 8'd25);
    m  = {1'b1, sm[22:0]};
    r = '0;
    r.lat  = fl ? 8'd3 : 8'd3 + d;
    r.nld  = {7'd0, !fl};
    r.nsh  = fl ? 8'd0 : d;
    r.ncl  = {7'd0, fl};
    r.sreg = fl ? 24'd0 : m >> d;
    r.exp  = bg[30:23];
    r.frac = bg[22:0];
    r.sgn  = bg[31];
    r.sub  = x[31] ^ y[31];
    r.swp  = !ab;
`ifdef FP_ALIGN_STICKY_EN
    r.stk = fl ? (sm[30:23] != 8'd0) : |({1'b0, m} & ((25'd1 << d) - 25'd1));
`endif
    return r;
  endfunction

  // Drives one operation, models the downstream register and records what the DUT presented.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int poke_k, output res_t o);
    logic [23:0] sreg;
    int k;
    exp_q.push_back(model(x, y));
    o = '0;
    sreg = 24'hABCDEF;
    @(negedge clk);
    a = x; b = y; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == poke_k) begin start = 1; a = 32'h3F800000; b = 32'h7F000000; end
      else if (k == poke_k + 1) start = 0;
      if (int'(sr_load) + int'(sr_shift) + int'(sr_clear) > 1 || !busy) o.bad = 1;
      if ((k == 1 || done) && (sr_load || sr_shift || sr_clear)) o.bad = 1;
      if (sr_load)  begin o.nld = o.nld + 8'd1; sreg = {1'b1, sr_data}; end
      if (sr_shift) begin o.nsh = o.nsh + 8'd1; sreg = sreg >> 1; end
      if (sr_clear) begin o.ncl = o.ncl + 8'd1; sreg = '0; end
      if (done) break;
    end
    start = 0;
    o.lat  = done ? 8'(k) : 8'hFF;
    o.sreg = sreg;
    o.exp  = exp_out;
    o.frac = big_frac;
    o.sgn  = sign_big;
    o.sub  = eff_sub;
    o.swp  = swap;
    o.stk  = sticky;
    @(negedge clk);
    if (busy || done || exp_out !== o.exp || big_frac !== o.frac || swap !== o.swp || sticky !== o.stk) o.bad = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, sr_data, sr_load, sr_shift, sr_clear, exp_out, big_frac, sign_big, eff_sub, swap, sticky} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b done=%b cmd=%b%b%b exp=%h required all zero", busy, done, sr_load, sr_shift, sr_clear, exp_out);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, sr_load, sr_shift, sr_clear, exp_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_idle got busy=%b done=%b cmd=%b%b%b required 0", busy, done, sr_load, sr_shift, sr_clear);
    end
  endtask

  task automatic test_align();
    logic [31:0] va [8] = '{32'h40400000, 32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'hBF800000, 32'hC2F00000, 32'h7F800000, 32'h3F7FFFFF};
    logic [31:0] vb [8] = '{32'h3F800000, 32'h41000000, 32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h3E000000, 32'h7F000001, 32'h3F800000};
    res_t o, e;
    for (int i = 0; i < 14; i++) begin
      logic [31:0] x, y;
      if (i < 8) begin x = va[i]; y = vb[i]; end
      else begin
        x = $urandom;
        y = {1'($urandom_range(0, 1)), x[30:23] - 8'($urandom_range(0, 26)), 23'($urandom)};
      end
      run_op(x, y, -5, o);
      e = exp_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL align a=%h b=%h got=%h required=%h", x, y, o, e);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] va [6] = '{32'h4C000000, 32'h4B800000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
    logic [31:0] vb [6] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h00400000, 32'h80400000};
    res_t o, e;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], -5, o);
      e = exp_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL flush a=%h b=%h got=%h required=%h", va[i], vb[i], o, e);
      end
    end
  endtask

  task automatic test_sticky();
    logic [31:0] va [4] = '{32'h3FC00001, 32'h3F800001, 32'h3F800000, 32'h41000007};
    logic [31:0] vb [4] = '{32'h3F400001, 32'h3F000001, 32'h3F000000, 32'h3F800004};
    res_t o, e;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], -5, o);
      e = exp_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL sticky a=%h b=%h got=%h required=%h", va[i], vb[i], o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    for (int i = 3; i <= 5; i++) begin
      run_op(32'h41000000, 32'h3F800000, i, o);
      e = exp_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL start_ignored poke=%0d got=%h required=%h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    a = 32'h41000000; b = 32'h3F800000; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (sr_shift !== 1'b1 || exp_out !== 8'h82) begin
      n_bad++;
      $display("FAIL mid_pre_reset got shift=%b exp=%h required shift=1 exp=82", sr_shift, exp_out);
    end
    rst_n = 0;
    #1;
    n_vec++;
    if ({busy, done, sr_data, sr_load, sr_shift, sr_clear, exp_out, big_frac, sign_big, eff_sub, swap, sticky} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset got busy=%b shift=%b exp=%h frac=%h swap=%b required all zero", busy, sr_shift, exp_out, big_frac, swap);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy || sr_clear) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL mid_no_done got active_cycles=%0d required=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_align();
    test_flush();
    test_sticky();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
